// File: rtl/bram_port_arbiter.sv
// rtl/bram_port_arbiter.sv - round-robin arbiter sharing one BRAM port among NUM_CH requesters
//
// Ports:
//   CLK, RST                    sole clock, synchronous active-high reset
//   req_valid/req_ready         per-channel request handshake (ready is combinational)
//   req_write                   per-channel direction, 1 = write
//   req_addr/req_wdata/req_be   per-channel packed word address, write data, byte enables
//   rsp_valid, rsp_data         one-hot response strobe, response data (held when idle)
//   bramAddr/bramDout/bramWEN   BRAM byte address, write data, byte write enables
//   bramEN, bramCLK, bramRST    BRAM enable, clock and reset pass-through
//   bramDin                     BRAM read data, valid RD_LAT cycles after the enable cycle
//
// Optional: define BRAM_ARB_WRACK_EN to return a zero-data response for every write.

module bram_port_arbiter #(
  parameter int NUM_CH = 2,
  parameter int ADDR_W = 14,
  parameter int RD_LAT = 1
) (
  input  logic                     CLK,
  input  logic                     RST,
  input  logic [NUM_CH-1:0]        req_valid,
  output logic [NUM_CH-1:0]        req_ready,
  input  logic [NUM_CH-1:0]        req_write,
  input  logic [NUM_CH*ADDR_W-1:0] req_addr,
  input  logic [NUM_CH*32-1:0]     req_wdata,
  input  logic [NUM_CH*4-1:0]      req_be,
  output logic [NUM_CH-1:0]        rsp_valid,
  output logic [31:0]              rsp_data,
  output logic [31:0]              bramAddr,
  output logic [31:0]              bramDout,
  output logic [3:0]               bramWEN,
  output logic                     bramEN,
  output logic                     bramCLK,
  output logic                     bramRST,
  input  logic [31:0]              bramDin
);

  localparam int PTR_W = $clog2(NUM_CH);
  // One tag stage per cycle between grant and the bramDin sampling edge.
  localparam int DEPTH = RD_LAT + 1;

  logic [PTR_W-1:0]  ptr_q, ptr_d;
  logic              grant_any;
  logic [PTR_W-1:0]  grant_idx;
  logic [PTR_W-1:0]  cand_idx;
  int                cand;

  logic              sel_write;
  logic [ADDR_W-1:0] sel_addr;
  logic [31:0]       sel_wdata;
  logic [3:0]        sel_be;

  logic              bram_en_q;
  logic [3:0]        bram_wen_q;
  logic [31:0]       bram_addr_q;
  logic [31:0]       bram_dout_q;

  logic [DEPTH-1:0]  tag_vld_q;
  logic [PTR_W-1:0]  tag_ch_q [DEPTH];
`ifdef BRAM_ARB_WRACK_EN
  logic [DEPTH-1:0]  tag_rd_q;
`endif

  logic [NUM_CH-1:0] rsp_valid_q;
  logic [31:0]       rsp_data_q;

  // Round-robin search starting at the pointer; first requester wins.
  always_comb begin
    grant_any = 1'b0;
    grant_idx = '0;
    cand      = 0;
    cand_idx  = '0;
    req_ready = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      cand = int'(ptr_q) + i;
      if (cand >= NUM_CH) cand = cand - NUM_CH;
      cand_idx = PTR_W'(cand);
      if (!grant_any && req_valid[cand_idx]) begin
        grant_any = 1'b1;
        grant_idx = cand_idx;
      end
    end
    // Nothing is granted while reset is held.
    if (RST) grant_any = 1'b0;
    if (grant_any) req_ready[grant_idx] = 1'b1;
  end

  always_comb begin
    sel_write = req_write[grant_idx];
    sel_addr  = req_addr[int'(grant_idx)*ADDR_W +: ADDR_W];
    sel_wdata = req_wdata[int'(grant_idx)*32 +: 32];
    sel_be    = req_be[int'(grant_idx)*4 +: 4];
    ptr_d     = ptr_q;
    if (grant_any) begin
      ptr_d = (grant_idx == PTR_W'(NUM_CH - 1)) ? '0 : grant_idx + 1'b1;
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      ptr_q       <= '0;
      bram_en_q   <= 1'b0;
      bram_wen_q  <= 4'b0000;
      bram_addr_q <= '0;
      bram_dout_q <= '0;
      tag_vld_q   <= '0;
      for (int i = 0; i < DEPTH; i++) tag_ch_q[i] <= '0;
`ifdef BRAM_ARB_WRACK_EN
      tag_rd_q    <= '0;
`endif
      rsp_valid_q <= '0;
      rsp_data_q  <= '0;
    end else begin
      ptr_q      <= ptr_d;
      bram_en_q  <= grant_any;
      // A write with all byte enables low still issues an enabled cycle.
      bram_wen_q <= (grant_any && sel_write) ? sel_be : 4'b0000;
      if (grant_any) begin
        bram_addr_q <= 32'(sel_addr) << 2;
        bram_dout_q <= sel_wdata;
      end

`ifdef BRAM_ARB_WRACK_EN
      tag_vld_q[0] <= grant_any;
      tag_rd_q[0]  <= ~sel_write;
`else
      tag_vld_q[0] <= grant_any && !sel_write;
`endif
      tag_ch_q[0] <= grant_idx;
      for (int i = 1; i < DEPTH; i++) begin
        tag_vld_q[i] <= tag_vld_q[i-1];
        tag_ch_q[i]  <= tag_ch_q[i-1];
`ifdef BRAM_ARB_WRACK_EN
        tag_rd_q[i]  <= tag_rd_q[i-1];
`endif
      end

      // Last tag stage lines up with the cycle bramDin carries its data.
      rsp_valid_q <= '0;
      if (tag_vld_q[DEPTH-1]) begin
        rsp_valid_q[tag_ch_q[DEPTH-1]] <= 1'b1;
`ifdef BRAM_ARB_WRACK_EN
        rsp_data_q <= tag_rd_q[DEPTH-1] ? bramDin : 32'h0;
`else
        rsp_data_q <= bramDin;
`endif
      end
    end
  end

  assign bramEN    = bram_en_q;
  assign bramWEN   = bram_wen_q;
  assign bramAddr  = bram_addr_q;
  assign bramDout  = bram_dout_q;
  assign bramCLK   = CLK;
  assign bramRST   = RST;
  assign rsp_valid = rsp_valid_q;
  assign rsp_data  = rsp_data_q;

endmodule

// File: doc/bram_port_arbiter.md
BRAM_PORT_ARBITER -- requirements
Module: bram_port_arbiter

Interface
REQ-001 SHALL have parameter NUM_CH, default 2, number of requester channels (legal range 2..8).
REQ-002 SHALL have parameter ADDR_W, default 14, word-address width (legal range 8..30).
REQ-003 SHALL have parameter RD_LAT, default 1, BRAM read latency in cycles (legal range 1..3).
REQ-004 SHALL have ports: CLK  in  1  sole clock; RST  in  1  synchronous active-high reset.
REQ-005 SHALL have ports: req_valid  in  NUM_CH  per-channel request; req_ready  out  NUM_CH  per-channel grant; req_write  in  NUM_CH  1=write.
REQ-006 SHALL have ports: req_addr  in  NUM_CH*ADDR_W  word addresses; req_wdata  in  NUM_CH*32  write data; req_be  in  NUM_CH*4  byte enables.
REQ-007 SHALL have ports: rsp_valid  out  NUM_CH  one-hot response strobe; rsp_data  out  32  read data.
REQ-008 SHALL have ports: bramAddr  out  32  byte address; bramDout  out  32  write data; bramWEN  out  4  byte write enables; bramEN  out  1  enable.
REQ-009 SHALL have ports: bramCLK  out  1  equals CLK; bramRST  out  1  equals RST; bramDin  in  32  read data.
REQ-010 SHALL implement exactly one clock domain (CLK) with synchronous, active-high reset (RST).

Function
REQ-011 SHALL drive bramAddr as {zeros, word address, 2'b00}, with zeros filling bits above ADDR_W+1.
REQ-012 SHALL arbitrate round-robin across channels: the search starts at pointer P, and the first channel with req_valid high is granted.
REQ-013 SHALL assert at most one req_ready bit per cycle, and only for a channel whose req_valid is high; req_ready is combinational from req_valid and P.
REQ-014 SHALL advance P to (k+1) mod NUM_CH after a grant to channel k, and SHALL leave P unchanged in cycles with no grant.
REQ-015 SHALL treat a request as accepted on the rising edge where req_valid[k] and req_ready[k] are both high.
REQ-016 SHALL, for a request accepted at edge A, register bramEN=1, bramAddr, bramDout and bramWEN on edge A; these are visible for exactly one cycle.
REQ-017 SHALL set bramWEN to req_be for writes and to 4'b0000 for reads; bramWEN bit 3 enables byte [31:24].
REQ-018 SHALL issue a write with req_be=0 as a BRAM cycle with bramEN=1 and bramWEN=0, with no memory change.
REQ-019 SHALL drive bramEN=0 and bramWEN=0 in any cycle following an edge with no grant.
REQ-020 SHALL sample bramDin RD_LAT cycles after the bramEN cycle.
REQ-021 SHALL pulse rsp_valid[k] for exactly one cycle, with rsp_data holding the sampled word, RD_LAT+1 cycles after the bramEN cycle.
REQ-022 SHALL sustain one accepted request per cycle (full throughput) using a RD_LAT+1 deep tag pipeline holding {valid, channel, is_read}.
REQ-023 SHALL return responses in issue order, with no reordering across channels.
REQ-024 SHALL hold rsp_data at its last value when rsp_valid is all zero.

Reset
REQ-025 SHALL, while RST is high, hold req_ready=0, bramEN=0, bramWEN=0, bramAddr=0, bramDout=0, rsp_valid=0, rsp_data=0 and P=0.
REQ-026 SHALL clear the tag pipeline on reset, so reads in flight when RST asserts produce no response.
REQ-027 SHALL accept requests from the first cycle in which RST is low.

Configuration
REQ-028 SHALL support the macro BRAM_ARB_WRACK_EN.
REQ-029 SHALL, with BRAM_ARB_WRACK_EN defined, pulse rsp_valid[k] for an accepted write at the read-response latency, with rsp_data=0.
REQ-030 SHALL, without BRAM_ARB_WRACK_EN, generate no response for writes, and the tag pipeline SHALL NOT store is_read.

Verification
REQ-031 SHALL verify: NUM_CH=2, RD_LAT=1; ch0 reads word 0x0010 with memory holding 0xDEADBEEF -> bramAddr=0x00000040 one cycle later; rsp_valid=2'b01 and rsp_data=0xDEADBEEF 3 cycles after acceptance.
REQ-032 SHALL verify: ch0 and ch1 both hold req_valid high for 4 cycles -> grants ch0,ch1,ch0,ch1, then 4 responses in that order.
REQ-033 SHALL verify: ch1 writes 0x11223344 with be=4'b0011 to word 5 over 0xFFFFFFFF, then reads word 5 -> 0xFFFF3344; bramWEN=4'b0011 on the write cycle.
REQ-034 SHALL verify: RD_LAT=3 with back-to-back reads on 3 channels (NUM_CH=3) -> 3 consecutive rsp_valid pulses with correct data and no gaps.
REQ-035 SHALL verify: RST asserted one cycle after a read is accepted -> no rsp_valid ever appears for that read; P=0; first post-reset grant goes to ch0 when all channels request.
REQ-036 SHALL verify: a write with BRAM_ARB_WRACK_EN defined -> rsp_valid pulses with rsp_data=0 at RD_LAT+2 cycles after acceptance; without the macro -> no pulse.
